// File: rtl/factor_judge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | factor_judge_if : digit/target/submit bus and verdict outputs of the judge |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface factor_judge_if;
  logic [3:0] DIG1_IN;
  logic [3:0] DIG2_IN;
  logic [3:0] DIG3_IN;
  logic [9:0] TARGET_IN;
  logic       SUBMIT_IN;
  logic       NEW_GAME_IN;
  logic [1:0] RESULT_OUT;
  logic [9:0] PRODUCT_OUT;
  logic [6:0] SCORE_OUT;
  logic [3:0] TRIES_OUT;
  logic       GAME_OVER_OUT;

  modport master (
    output DIG1_IN, DIG2_IN, DIG3_IN, TARGET_IN, SUBMIT_IN, NEW_GAME_IN,
    input  RESULT_OUT, PRODUCT_OUT, SCORE_OUT, TRIES_OUT, GAME_OVER_OUT
  );

  modport slave (
    input  DIG1_IN, DIG2_IN, DIG3_IN, TARGET_IN, SUBMIT_IN, NEW_GAME_IN,
    output RESULT_OUT, PRODUCT_OUT, SCORE_OUT, TRIES_OUT, GAME_OVER_OUT
  );
endinterface
`default_nettype wire

// File: rtl/factor_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | factor_judge : checks DIG1*DIG2*DIG3 against a target, keeps score/tries  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module factor_judge #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int MAX_TRIES   = 3,
  parameter int SCORE_MAX   = 99
) (
  input logic           CLK,
  input logic           RST,
  factor_judge_if.slave bus
);

  localparam int                    c_HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0]   c_HOLD_LOAD  = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]            c_TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [6:0]            c_SCORE_MAX  = 7'(SCORE_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_MUL2 = 3'd2,
    S_CMP  = 3'd3,
    S_SHOW = 3'd4,
    S_OVER = 3'd5
  } state_t;

  state_t              r_state;
  logic [9:0]          r_acc;
  logic [9:0]          r_m;
  logic [3:0]          r_q;
  logic [1:0]          r_step;
  logic [3:0]          r_dig3;
  logic [9:0]          r_target;
  logic                r_invalid;
  logic [c_HOLD_W-1:0] r_hold;
  logic [1:0]          r_result;
  logic [9:0]          r_product;
  logic [6:0]          r_score;
  logic [3:0]          r_tries;
  logic                r_game_over;

  logic [9:0] w_sum;
  logic       w_last_step;
  logic       w_bad_digit;

  // One shift-add step; four steps cover a 4-bit multiplier.
  assign w_sum       = r_q[0] ? (r_acc + r_m) : r_acc;
  assign w_last_step = (r_step == 2'd3);
  assign w_bad_digit = (bus.DIG1_IN == 4'd0) || (bus.DIG1_IN > 4'd9) ||
                       (bus.DIG2_IN == 4'd0) || (bus.DIG2_IN > 4'd9) ||
                       (bus.DIG3_IN == 4'd0) || (bus.DIG3_IN > 4'd9);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_step      <= '0;
      r_dig3      <= '0;
      r_target    <= '0;
      r_invalid   <= 1'b0;
      r_hold      <= '0;
      r_result    <= 2'b00;
      r_product   <= '0;
      r_score     <= '0;
      r_tries     <= c_TRIES_INIT;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.NEW_GAME_IN) begin
            r_score     <= '0;
            r_tries     <= c_TRIES_INIT;
            r_game_over <= 1'b0;
          end else if (bus.SUBMIT_IN) begin
            r_acc     <= '0;
            r_m       <= {6'd0, bus.DIG1_IN};
            r_q       <= bus.DIG2_IN;
            r_dig3    <= bus.DIG3_IN;
            r_target  <= bus.TARGET_IN;
            r_invalid <= w_bad_digit;
            r_step    <= '0;
            r_result  <= 2'b10;
            r_state   <= S_MUL1;
          end
        end

        S_MUL1: begin
          r_step <= r_step + 2'd1;
          if (w_last_step) begin
            // Partial product becomes the multiplicand for the third digit.
            r_acc   <= '0;
            r_m     <= w_sum;
            r_q     <= r_dig3;
            r_state <= S_MUL2;
          end else begin
            r_acc <= w_sum;
            r_m   <= r_m << 1;
            r_q   <= r_q >> 1;
          end
        end

        S_MUL2: begin
          r_step <= r_step + 2'd1;
          r_acc  <= w_sum;
          r_m    <= r_m << 1;
          r_q    <= r_q >> 1;
          if (w_last_step) begin
            r_state <= S_CMP;
          end
        end

        S_CMP: begin
          r_product <= r_acc;
          if (!r_invalid && (r_acc == r_target)) begin
            r_result <= 2'b11;
            if (r_score < c_SCORE_MAX) begin
              r_score <= r_score + 7'd1;
            end
          end else begin
            r_result <= 2'b01;
            if (r_tries != 4'd0) begin
              r_tries <= r_tries - 4'd1;
            end
          end
          r_hold  <= c_HOLD_LOAD;
          r_state <= S_SHOW;
        end

        S_SHOW: begin
          if (r_hold == '0) begin
            r_result <= 2'b00;
            if (r_tries == 4'd0) begin
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end

        S_OVER: begin
          if (bus.NEW_GAME_IN) begin
            r_score     <= '0;
            r_tries     <= c_TRIES_INIT;
            r_game_over <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_result <= 2'b00;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.RESULT_OUT    = r_result;
  assign bus.PRODUCT_OUT   = r_product;
  assign bus.SCORE_OUT     = r_score;
  assign bus.TRIES_OUT     = r_tries;
  assign bus.GAME_OVER_OUT = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_factor_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_factor_judge : directed stimulus with queued expected verdicts          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_factor_judge;

  localparam int c_HOLD = 4;

  typedef struct {
    logic [1:0] res;
    int         prod;
    int         score;
    int         tries;
    logic       go;
  } exp_t;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;
  int   n_done;
  exp_t exp_q[$];

  factor_judge_if bus ();

  factor_judge #(
    .HOLD_CYCLES (c_HOLD),
    .MAX_TRIES   (3),
    .SCORE_MAX   (99)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation each time a verdict appears after the busy code.
  initial begin
    logic [1:0] prev;
    logic [1:0] r;
    int         busy;
    int         hold;
    bit         have;
    exp_t       e;
    prev = 2'b00; busy = 0; hold = 0; have = 0;
    forever begin
      @(negedge CLK);
      r = bus.RESULT_OUT;
      if (r == 2'b10) begin
        busy++;
      end else if ((r == 2'b01 || r == 2'b11) && prev == 2'b10) begin
        if (exp_q.size() == 0) begin
          check("unexpected_verdict", 1, 0);
          have = 0;
        end else begin
          e = exp_q.pop_front();
          have = 1;
          check("result", int'(r), int'(e.res));
          check("product", int'(bus.PRODUCT_OUT), e.prod);
          check("score", int'(bus.SCORE_OUT), e.score);
          check("tries", int'(bus.TRIES_OUT), e.tries);
          check("busy_cycles", busy, 9);
        end
        hold = 1;
        busy = 0;
      end else if (r == 2'b01 || r == 2'b11) begin
        hold++;
      end else begin
        if ((prev == 2'b01 || prev == 2'b11) && have) begin
          check("hold_cycles", hold, c_HOLD);
          check("game_over", int'(bus.GAME_OVER_OUT), int'(e.go));
          have = 0;
          n_done++;
        end
        busy = 0;
      end
      prev = r;
    end
  end

  task automatic submit(input int d1, input int d2, input int d3, input int tgt);
    @(posedge CLK); #1;
    bus.DIG1_IN   = 4'(d1);
    bus.DIG2_IN   = 4'(d2);
    bus.DIG3_IN   = 4'(d3);
    bus.TARGET_IN = 10'(tgt);
    bus.SUBMIT_IN = 1'b1;
    @(posedge CLK); #1;
    bus.SUBMIT_IN = 1'b0;
  endtask

  task automatic push(input logic [1:0] res, input int prod, input int score,
                      input int tries, input logic go);
    exp_t e;
    e.res = res; e.prod = prod; e.score = score; e.tries = tries; e.go = go;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int start;
    bit ok;
    start = n_done;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (n_done != start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("verdict_timeout", 0, 1);
  endtask

  task automatic pulse_new_game();
    @(posedge CLK); #1;
    bus.NEW_GAME_IN = 1'b1;
    @(posedge CLK); #1;
    bus.NEW_GAME_IN = 1'b0;
  endtask

  task automatic count_active(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (bus.RESULT_OUT != 2'b00) n++;
    end
  endtask

  initial begin
    int n;
    n_checks = 0; n_errors = 0; n_done = 0;
    RST = 1'b1;
    bus.DIG1_IN = '0; bus.DIG2_IN = '0; bus.DIG3_IN = '0;
    bus.TARGET_IN = '0; bus.SUBMIT_IN = 1'b0; bus.NEW_GAME_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_result", int'(bus.RESULT_OUT), 0);
    check("rst_product", int'(bus.PRODUCT_OUT), 0);
    check("rst_score", int'(bus.SCORE_OUT), 0);
    check("rst_tries", int'(bus.TRIES_OUT), 3);
    check("rst_game_over", int'(bus.GAME_OVER_OUT), 0);

    push(2'b11, 24, 1, 3, 1'b0);
    submit(2, 3, 4, 24);
    wait_done();

    push(2'b01, 729, 1, 2, 1'b0);
    submit(9, 9, 9, 728);
    wait_done();

    push(2'b01, 0, 1, 1, 1'b0);
    submit(0, 5, 5, 0);
    wait_done();

    // Second submit with new digits lands in MUL1 and must be dropped.
    push(2'b11, 27, 2, 1, 1'b0);
    submit(3, 3, 3, 27);
    bus.DIG1_IN = 4'd1; bus.DIG2_IN = 4'd1; bus.DIG3_IN = 4'd1;
    bus.SUBMIT_IN = 1'b1;
    @(posedge CLK); #1;
    bus.SUBMIT_IN = 1'b0;
    wait_done();
    count_active(4, n);
    check("no_second_check", n, 0);

    push(2'b01, 125, 2, 0, 1'b1);
    submit(5, 5, 5, 1);
    wait_done();

    submit(2, 3, 4, 24);
    count_active(12, n);
    check("over_ignores_submit", n, 0);
    check("over_sticky", int'(bus.GAME_OVER_OUT), 1);
    check("over_product_hold", int'(bus.PRODUCT_OUT), 125);

    pulse_new_game();
    @(negedge CLK);
    check("ng_tries", int'(bus.TRIES_OUT), 3);
    check("ng_game_over", int'(bus.GAME_OVER_OUT), 0);
    check("ng_score", int'(bus.SCORE_OUT), 0);

    // Reset at E6: submit returns after E1, four more edges reach E5.
    submit(2, 3, 4, 24);
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check("midrst_result", int'(bus.RESULT_OUT), 0);
    check("midrst_product", int'(bus.PRODUCT_OUT), 0);
    check("midrst_score", int'(bus.SCORE_OUT), 0);
    check("midrst_tries", int'(bus.TRIES_OUT), 3);

    push(2'b11, 8, 1, 3, 1'b0);
    submit(2, 2, 2, 8);
    wait_done();

    // Simultaneous submit and new game in IDLE: new game wins.
    @(posedge CLK); #1;
    bus.DIG1_IN = 4'd2; bus.DIG2_IN = 4'd2; bus.DIG3_IN = 4'd2;
    bus.TARGET_IN = 10'd8;
    bus.SUBMIT_IN = 1'b1; bus.NEW_GAME_IN = 1'b1;
    @(posedge CLK); #1;
    bus.SUBMIT_IN = 1'b0; bus.NEW_GAME_IN = 1'b0;
    count_active(12, n);
    check("newgame_beats_submit", n, 0);
    check("newgame_score_clear", int'(bus.SCORE_OUT), 0);
    check("newgame_product_hold", int'(bus.PRODUCT_OUT), 8);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
